bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001: Parameter DIGITS, default 3, SHALL set the number of packed BCD digits (legal range 1..8).
REQ-002: Parameter SATURATE, default 0, SHALL select the range-end mode: 0 = wrap around, 1 = hold at the range end.
REQ-003: Port Clock, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004: Port Reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005: Port Enable, input, 1 bit, SHALL request one count step in the current cycle.
REQ-006: Port Up, input, 1 bit, SHALL select the step direction: 1 = increment, 0 = decrement.
REQ-007: Port Load, input, 1 bit, SHALL request a parallel load of LoadValue.
REQ-008: Port LoadValue, input, 4*DIGITS bits, SHALL carry the packed BCD load value; the least-significant digit is in bits [3:0].
REQ-009: Port Count, output, 4*DIGITS bits, SHALL be the registered packed BCD count.
REQ-010: Port CarryOut, output, 1 bit, SHALL be a registered one-cycle pulse flagging an increment from all-9s.
REQ-011: Port BorrowOut, output, 1 bit, SHALL be a registered one-cycle pulse flagging a decrement from zero.
REQ-012: Port LoadError, output, 1 bit, SHALL be a registered one-cycle pulse flagging a rejected load.
REQ-013: Port Zero, output, 1 bit, SHALL be high exactly when Count is all zeros (combinational decode of Count).

Function
REQ-014: Priority SHALL be fixed: Reset, then Load, then Enable, then hold.
REQ-015: A load SHALL be valid only when every LoadValue nibble is at most 9.
REQ-016: A valid load SHALL set Count to LoadValue on the next edge, with CarryOut, BorrowOut and LoadError all 0.
REQ-017: An invalid load SHALL leave Count unchanged, set LoadError to 1 for one cycle, and ignore Enable that cycle.
REQ-018: When Enable is high with Up=1, the increment SHALL add 1 to digit 0; each digit that was 9 SHALL become 0 and pass a carry to the next digit; each other digit that receives a carry SHALL increment by 1; the update SHALL complete in one cycle for all DIGITS.
REQ-019: When Enable is high with Up=0, the decrement SHALL subtract 1 from digit 0; each digit that was 0 SHALL become 9 and pass a borrow to the next digit; the update SHALL complete in one cycle.
REQ-020: Incrementing from all-9s with SATURATE=0 SHALL set Count to all zeros and pulse CarryOut.
REQ-021: Incrementing from all-9s with SATURATE=1 SHALL hold Count at all-9s and pulse CarryOut.
REQ-022: Decrementing from zero with SATURATE=0 SHALL set Count to all-9s and pulse BorrowOut.
REQ-023: Decrementing from zero with SATURATE=1 SHALL hold Count at zero and pulse BorrowOut.
REQ-024: CarryOut, BorrowOut and LoadError SHALL be 0 in every cycle without a qualifying event; at most one of the three SHALL be high in any cycle.
REQ-025: CarryOut and BorrowOut SHALL be aligned with the edge that updates Count, not the input cycle.
REQ-026: When Enable is low and Load is low, Count SHALL hold its value and all pulse outputs SHALL be 0.
REQ-027: Direction changes (Up toggling) SHALL take effect on the very next enabled step, with no lost or extra count.
REQ-028: Count SHALL never contain a nibble greater than 9 in any reachable state.

Reset
REQ-029: Reset high at an edge SHALL set Count to 0 and CarryOut, BorrowOut and LoadError to 0; Zero SHALL then read 1.
REQ-030: Reset SHALL override Load and Enable in the same cycle, including a reset arriving during continuous counting.
REQ-031: Counting SHALL resume from 0 on the first edge after Reset deasserts, if Enable is high.

Verification (DIGITS=3)
REQ-032: Apply Reset, then Enable=1 and Up=1 for 1000 cycles -> Count steps 000 through 999 then returns to 000; CarryOut pulses exactly once, on the 999 to 000 edge.
REQ-033: Load 0x199, then one increment -> Count=0x200, CarryOut=0; then one decrement -> Count=0x199.
REQ-034: From Count=0x000 with SATURATE=0, one decrement -> Count=0x999 and BorrowOut=1; with SATURATE=1 -> Count=0x000 and BorrowOut=1.
REQ-035: Load=1 with LoadValue=0x1A3 and Enable=1 from Count=0x042 -> Count stays 0x042 and LoadError=1 for one cycle.
REQ-036: Reset asserted in the same cycle as Load=1 with 0x555 and Enable=1 -> Count=0x000, all pulses 0 and Zero=1.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Packed-BCD up/down counter with parallel load, range-end wrap or saturate, and pulse flags.
// Latency: Count and all pulse outputs are registered and update one edge after the request.
// Backpressure: none; a step or load is accepted in every cycle it is requested.
module bcd_updown_counter #(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadValue,
  output logic [4*DIGITS-1:0]   Count,
  output logic                  CarryOut,
  output logic                  BorrowOut,
  output logic                  LoadError,
  output logic                  Zero
);

  logic [4*DIGITS-1:0] step_cnt;
  logic                range_end;
  logic                load_ok;

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (LoadValue[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Ripple through all digits in one cycle; a carry/borrow leaving the top digit marks the range end.
  always_comb begin
    logic       c;
    logic [3:0] d;
    c        = 1'b1;
    step_cnt = Count;
    for (int i = 0; i < DIGITS; i++) begin
      d = Count[4*i +: 4];
      if (c) begin
        if (Up) begin
          if (d == 4'd9) begin
            step_cnt[4*i +: 4] = 4'd0;
          end else begin
            step_cnt[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            step_cnt[4*i +: 4] = 4'd9;
          end else begin
            step_cnt[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    range_end = c;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Count     <= '0;
      CarryOut  <= 1'b0;
      BorrowOut <= 1'b0;
      LoadError <= 1'b0;
    end else begin
      CarryOut  <= 1'b0;
      BorrowOut <= 1'b0;
      LoadError <= 1'b0;
      if (Load) begin
        if (load_ok) Count <= LoadValue;
        else         LoadError <= 1'b1;
      end else if (Enable) begin
        if (range_end) begin
          if (Up) CarryOut  <= 1'b1;
          else    BorrowOut <= 1'b1;
        end
        if (!(SATURATE && range_end)) Count <= step_cnt;
      end
    end
  end

  assign Zero = (Count == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: wrap and saturate instances share stimulus; vector table plus long counting runs.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst, en, up, ld;
  logic [11:0] lv;
  logic [11:0] cnt0, cnt1;
  logic        co0, bo0, le0, z0, co1, bo1, le1, z1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(3), .SATURATE(1'b0)) dut_wrap (
    .Clock(clk), .Reset(rst), .Enable(en), .Up(up), .Load(ld), .LoadValue(lv),
    .Count(cnt0), .CarryOut(co0), .BorrowOut(bo0), .LoadError(le0), .Zero(z0)
  );

  bcd_updown_counter #(.DIGITS(3), .SATURATE(1'b1)) dut_sat (
    .Clock(clk), .Reset(rst), .Enable(en), .Up(up), .Load(ld), .LoadValue(lv),
    .Count(cnt1), .CarryOut(co1), .BorrowOut(bo1), .LoadError(le1), .Zero(z1)
  );

  typedef struct {
    logic        rst, en, up, ld;
    logic [11:0] lv;
    logic [11:0] e0, e1;
    logic        co, bo, le;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [11:0] v, input logic [11:0] x0, input logic [11:0] x1,
                     input logic c, input logic b, input logic le);
    vec_t t;
    t.rst = r; t.en = e; t.up = u; t.ld = l; t.lv = v;
    t.e0 = x0; t.e1 = x1; t.co = c; t.bo = b; t.le = le;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [11:0] x0, input logic [11:0] x1,
                           input logic c0, input logic c1, input logic b0, input logic b1,
                           input logic l);
    check({tag, " count_wrap"}, 32'(cnt0), 32'(x0));
    check({tag, " count_sat"},  32'(cnt1), 32'(x1));
    check({tag, " carry_wrap"}, 32'(co0), 32'(c0));
    check({tag, " carry_sat"},  32'(co1), 32'(c1));
    check({tag, " borrow_wrap"}, 32'(bo0), 32'(b0));
    check({tag, " borrow_sat"},  32'(bo1), 32'(b1));
    check({tag, " loaderr_wrap"}, 32'(le0), 32'(l));
    check({tag, " loaderr_sat"},  32'(le1), 32'(l));
    check({tag, " zero_wrap"}, 32'(z0), 32'(x0 == 12'h000));
    check({tag, " zero_sat"},  32'(z1), 32'(x1 == 12'h000));
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b0; ld = 1'b0; lv = 12'h000;

    //   rst en up ld  lv       wrap     sat      co bo le
    add(1, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0);
    add(0, 0, 0, 1, 12'h199, 12'h199, 12'h199, 0, 0, 0);
    add(0, 1, 1, 0, 12'h000, 12'h200, 12'h200, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h199, 12'h199, 0, 0, 0);
    add(0, 0, 0, 1, 12'h999, 12'h999, 12'h999, 0, 0, 0);
    add(0, 1, 1, 0, 12'h000, 12'h000, 12'h999, 1, 0, 0);
    add(0, 0, 1, 0, 12'h000, 12'h000, 12'h999, 0, 0, 0);
    add(0, 0, 0, 1, 12'h000, 12'h000, 12'h000, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h999, 12'h000, 0, 1, 0);
    add(0, 0, 0, 0, 12'h000, 12'h999, 12'h000, 0, 0, 0);
    add(0, 0, 0, 1, 12'h042, 12'h042, 12'h042, 0, 0, 0);
    add(0, 1, 1, 1, 12'h1A3, 12'h042, 12'h042, 0, 0, 1);
    add(0, 0, 0, 0, 12'h000, 12'h042, 12'h042, 0, 0, 0);
    add(0, 0, 0, 1, 12'h9F0, 12'h042, 12'h042, 0, 0, 1);
    add(0, 1, 1, 1, 12'h123, 12'h123, 12'h123, 0, 0, 0);
    add(0, 0, 0, 1, 12'h099, 12'h099, 12'h099, 0, 0, 0);
    add(0, 1, 1, 0, 12'h000, 12'h100, 12'h100, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h099, 12'h099, 0, 0, 0);
    add(0, 0, 0, 1, 12'h090, 12'h090, 12'h090, 0, 0, 0);
    add(0, 1, 1, 0, 12'h000, 12'h091, 12'h091, 0, 0, 0);
    add(1, 1, 1, 1, 12'h555, 12'h000, 12'h000, 0, 0, 0);
    add(0, 1, 1, 0, 12'h000, 12'h001, 12'h001, 0, 0, 0);
    add(0, 1, 1, 0, 12'h000, 12'h002, 12'h002, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h001, 12'h001, 0, 0, 0);
    add(0, 1, 1, 0, 12'h000, 12'h002, 12'h002, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h001, 12'h001, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0);
    add(0, 1, 0, 0, 12'h000, 12'h999, 12'h000, 0, 1, 0);
    add(1, 1, 1, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0);
    add(0, 1, 1, 0, 12'h000, 12'h001, 12'h001, 0, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; up = vecs[i].up; ld = vecs[i].ld; lv = vecs[i].lv;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1,
                vecs[i].co, vecs[i].co, vecs[i].bo, vecs[i].bo, vecs[i].le);
    end

    // Full 1000-step up run from reset: wrap returns to 000, saturate sticks at 999.
    rst = 1'b1; en = 1'b0; ld = 1'b0; up = 1'b1;
    @(posedge clk); #1;
    check_all("run_reset", 12'h000, 12'h000, 0, 0, 0, 0, 0);
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk); #1;
      check_all($sformatf("up%0d", k), to_bcd(k % 1000), to_bcd(k > 999 ? 999 : k),
                k == 1000, k == 1000, 0, 0, 0);
    end

    // Short down run: wrap borrows out of 000, saturate counts down from 999.
    up = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check_all($sformatf("dn%0d", k), to_bcd(1000 - k), to_bcd(999 - k), 0, 0, k == 1, 0, 0);
    end

    en = 1'b0;
    @(posedge clk); #1;
    check_all("hold", to_bcd(995), to_bcd(994), 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
